// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encodings, buffer entry layout and occupancy states
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int NUM_OPS       = 13;

  typedef enum logic [3:0] {
    OP_NOT_A = 4'd0,
    OP_NOT_B = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_XNOR  = 4'd5,
    OP_SLT   = 4'd6,
    OP_SGT   = 4'd7,
    OP_LSL   = 4'd8,
    OP_LSR   = 4'd9,
    OP_ASR   = 4'd10,
    OP_ADD   = 4'd11,
    OP_SUB   = 4'd12
  } op_e;

  // Field order matches the packed entry carried through result_buf2.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] result;
    logic                     zero;
    logic                     neg;
    logic                     err;
  } alu_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/result_buf2.sv
// rtl/result_buf2.sv - generic 2-entry valid/ready buffer with registered handshakes
module result_buf2
  import alu_pkg::*;
#(
  parameter int EW = 35
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [EW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [EW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  buf_state_e    state;
  logic [EW-1:0] tail;
  logic          push;
  logic          pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // out_data is the head register; it keeps its value when the buffer drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      out_data  <= '0;
      tail      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            tail     <= in_data;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (pop && !push) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end else if (push && pop) begin
            out_data <= in_data;
          end
        end
        FULL: begin
          if (pop) begin
            out_data <= tail;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result selection, flag generation and buffered output
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NUM_SRC = NUM_OPS,
  parameter int SEL_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC*WIDTH-1:0] src,
  input  logic [SEL_W-1:0]         op,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     zero,
  output logic                     neg,
  output logic                     op_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     err_clr,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int EW = WIDTH + 3;

  logic [WIDTH-1:0] sel_result;
  logic             illegal;
  logic [EW-1:0]    in_entry;
  logic [EW-1:0]    head;
  logic             push;

  // Illegal ops fall through with a zero result so nothing undefined is stored.
  always_comb begin
    sel_result = '0;
    illegal    = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (op == SEL_W'(k)) begin
        sel_result = src[k*WIDTH +: WIDTH];
        illegal    = 1'b0;
      end
    end
  end

  assign in_entry = {sel_result, ~|sel_result, sel_result[WIDTH-1], illegal};

  result_buf2 #(
    .EW(EW)
  ) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_entry),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (head),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign {result, zero, neg, op_err} = head;

  assign push = in_valid && in_ready;

  // Clear takes priority over a coincident illegal push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (push && illegal && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage
module tb_alu_result_stage;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        e;
  } ent_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] val;
    logic [31:0] er;
    logic        ez;
    logic        en;
    logic        ee;
  } vec_t;

  logic             clk;
  logic             reset_n;
  logic [12:0][31:0] srcv;
  logic [3:0]       op;
  logic             in_valid;
  logic             out_ready;
  logic             err_clr;

  logic             in_ready, zero, neg, op_err, out_valid;
  logic [31:0]      result;
  logic [7:0]       err_cnt;
  logic             in_ready2, zero2, neg2, op_err2, out_valid2;
  logic [31:0]      result2;
  logic [1:0]       err_cnt2;

  int   n_cmp;
  int   n_fail;
  ent_t q[$];
  ent_t hold;
  int   cnt;
  int   cnt2;
  vec_t tbl[8];

  alu_result_stage dut (
    .clk(clk), .reset_n(reset_n), .src(srcv), .op(op), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .zero(zero), .neg(neg), .op_err(op_err),
    .out_valid(out_valid), .out_ready(out_ready), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  alu_result_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .src(srcv), .op(op), .in_valid(in_valid),
    .in_ready(in_ready2), .result(result2), .zero(zero2), .neg(neg2), .op_err(op_err2),
    .out_valid(out_valid2), .out_ready(out_ready), .err_clr(err_clr), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t ref_entry(input logic [3:0] o);
    ent_t e;
    if (o < 4'd13) begin
      e.r = srcv[o];
      e.z = (e.r == 32'd0);
      e.n = e.r[31];
      e.e = 1'b0;
    end else begin
      e = '{r: 32'd0, z: 1'b1, n: 1'b0, e: 1'b1};
    end
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    hold = '0;
    cnt  = 0;
    cnt2 = 0;
  endtask

  task automatic randomize_src();
    for (int k = 0; k < 13; k++) begin
      case ($urandom_range(0, 7))
        0:       srcv[k] = 32'd0;
        1:       srcv[k] = 32'h8000_0000 | 32'($urandom_range(0, 3));
        default: srcv[k] = $urandom;
      endcase
    end
  endtask

  // Called at posedge+1 with this cycle's inputs applied; returns at next posedge+1.
  task automatic cycle();
    ent_t h;
    ent_t ne;
    bit   push;
    bit   pop;
    h = (q.size() != 0) ? q[0] : hold;
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("head", 64'({result, zero, neg, op_err}), 64'(h));
    check("err_cnt", 64'(err_cnt), 64'(cnt));
    check("dut2_head", 64'({in_ready2, out_valid2, result2, zero2, neg2, op_err2}),
          64'({q.size() < 2, q.size() != 0, h}));
    check("dut2_err_cnt", 64'(err_cnt2), 64'(cnt2));
    push = in_valid && (q.size() < 2);
    pop  = (q.size() != 0) && out_ready;
    ne   = ref_entry(op);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(ne);
    if (q.size() != 0) hold = q[0];
    if (err_clr) begin
      cnt  = 0;
      cnt2 = 0;
    end else if (push && ne.e) begin
      if (cnt < 255) cnt++;
      if (cnt2 < 3) cnt2++;
    end
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    tbl[0] = '{4'd11, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'd12, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{4'd2,  32'h0000_00F0, 32'h0000_00F0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{4'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{4'd3,  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{4'd13, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{4'd15, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{4'd9,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};

    // Reset with random activity on the inputs
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    op        = 4'd0;
    srcv      = '0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      randomize_src();
      op       = 4'($urandom_range(0, 15));
      in_valid = 1'($urandom);
      @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      check("rst_result", 64'(result), 64'd0);
    end
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Streaming table: one vector per cycle, result one cycle after acceptance
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      randomize_src();
      if (tbl[i].op < 4'd13) srcv[tbl[i].op] = tbl[i].val;
      op       = tbl[i].op;
      in_valid = 1'b1;
      cycle();
      check("tbl_result", 64'(result), 64'(tbl[i].er));
      check("tbl_flags", 64'({zero, neg, op_err}), 64'({tbl[i].ez, tbl[i].en, tbl[i].ee}));
      check("tbl_valid_ready", 64'({out_valid, in_ready}), 64'b11);
    end
    in_valid = 1'b0;
    cycle();
    check("tbl_err_cnt", 64'(err_cnt), 64'd2);

    // Backpressure: A, B fill the buffer, C is refused until space opens
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = 4'd4;
    srcv[4]   = 32'hAAAA_0001;
    cycle();
    srcv[4]   = 32'hBBBB_0002;
    cycle();
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    srcv[4]   = 32'hCCCC_0003;
    cycle();
    check("bp_hold_a", 64'(result), 64'hAAAA_0001);
    out_ready = 1'b1;
    cycle();
    check("bp_head_b", 64'(result), 64'hBBBB_0002);
    cycle();
    check("bp_head_c", 64'(result), 64'hCCCC_0003);
    in_valid = 1'b0;
    cycle();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Illegal ops: clear, five illegal pushes, then clear racing a push
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op = (i % 2 == 0) ? 4'd13 : 4'd15;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("ill_err_cnt", 64'(err_cnt), 64'd5);
    check("ill_sat_cnt2", 64'(err_cnt2), 64'd3);
    in_valid = 1'b1;
    op       = 4'd14;
    err_clr  = 1'b1;
    cycle();
    err_clr  = 1'b0;
    in_valid = 1'b0;
    check("clr_wins", 64'({err_cnt, 6'd0, err_cnt2}), 64'd0);
    cycle();

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      randomize_src();
      op        = 4'($urandom_range(0, 15));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      err_clr   = ($urandom_range(0, 31) == 0);
      cycle();
    end
    err_clr = 1'b0;

    // Async reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = 4'd7;
    srcv[7]   = 32'h5555_AAAA;
    cycle();
    cycle();
    cycle();
    check("full_before_rst", 64'({in_ready, out_valid}), 64'b01);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    model_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("no_stale", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Parametrised successor of the ALU result selector: picks one of NUM_SRC candidate results by op, computes zero, negative and illegal-op flags, and registers them in a 2-entry output buffer with valid/ready handshakes on both sides.
- Sits between the ALU function units (and multiplier) and downstream consumers (register write-back, system bus).
- Sustains one result per cycle under continuous flow and absorbs a one-cycle downstream stall without dropping data.
- Keeps a saturating illegal-op counter.

Parameters:
- WIDTH, 32, bit width of each candidate result and of the output.
- NUM_SRC, 13, number of candidate results; legal op values are 0..NUM_SRC-1.
- SEL_W, 4, op width; must satisfy 2**SEL_W >= NUM_SRC.
- CNT_W, 8, width of the illegal-op counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- src  in  NUM_SRC*WIDTH  packed candidates; candidate k is src[k*WIDTH +: WIDTH].
- op  in  SEL_W  selector; op 0..12 = not_a, not_b, and, or, xor, xnor, slt, sgt, lsl, lsr, asr, add, sub.
- in_valid  in  1  src and op are valid this cycle.
- in_ready  out  1  stage can accept this cycle.
- result  out  WIDTH  selected value at buffer head.
- zero  out  1  head result == 0.
- neg  out  1  head result MSB.
- op_err  out  1  head entry came from an illegal op.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- err_clr  in  1  synchronous clear of err_cnt.
- err_cnt  out  CNT_W  saturating count of accepted illegal ops.

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values: buffer EMPTY; out_valid=0, result=0, zero=0, neg=0, op_err=0, err_cnt=0; in_ready=1 once reset_n is high.
- Push: occurs when in_valid && in_ready at a rising edge.
  - Stored entry = {src[op], zero bit, MSB, err}.
  - For op >= NUM_SRC: stored result = 0 (never X), zero=1, neg=0, err=1.
- Pop: occurs when out_valid && out_ready.
- Latency: an accepted input appears on result/out_valid at the next cycle's outputs (1 cycle) when the buffer was empty or popping.
- FSM on occupancy:
  - EMPTY: in_ready=1, out_valid=0. Push -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Push and no pop -> FULL.
    - Pop and no push -> EMPTY.
    - Push and pop -> ONE, with the new entry as head.
  - FULL: in_ready=0, out_valid=1. Pop -> ONE; the second entry becomes head next cycle.
- in_ready depends only on state (registered), never combinationally on out_ready; there is no ready-to-ready path.
- Ordering: strict FIFO. Head outputs are stable while out_valid && !out_ready (no change until popped).
- Flags zero, neg and op_err always describe the current head entry. When EMPTY they hold their last values; consumers must qualify them with out_valid.
- err_cnt:
  - Increments by 1 on each push with an illegal op; saturates at 2**CNT_W-1.
  - err_clr sets it to 0 next edge.
  - err_clr coincident with an illegal push: clear wins, giving 0.
- Ignored inputs: in_valid while FULL is ignored (no push, no count).
- Reset asserted mid-operation: buffered entries are discarded immediately and all outputs return to reset values asynchronously.

Decomposition:
- Shared package alu_pkg:
  - op encodings OP_NOT_A=0 .. OP_SUB=12 and NUM_OPS=13;
  - default WIDTH;
  - the buffer-entry struct {result, zero, neg, err};
  - occupancy state enum EMPTY/ONE/FULL.
- Sub-module result_buf2: generic 2-entry valid/ready buffer parametrised on entry width, holding the occupancy FSM.
- Top level: selection, flag generation and err_cnt.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> out_valid=0, err_cnt=0, result=0. After release, in_ready=1.
- Streaming: op=11, src[11]=32'h0000_0005, in_valid=1, out_ready=1 for 4 cycles with op varying 11,12,2,0 -> four results in order, each 1 cycle after acceptance, in_ready stays 1.
- Flags: select src[12]=32'h8000_0000 -> neg=1, zero=0. Select src[3]=0 -> zero=1, neg=0.
- Backpressure: out_ready=0 while pushing A, B, C -> in_ready drops after B; C is not accepted; result holds A. Raise out_ready -> A then B delivered, then C accepted and delivered.
- Illegal op: op=13 and op=15 accepted -> result=0, op_err=1, zero=1, err_cnt=2. With CNT_W=2, 5 illegal pushes -> err_cnt=3. err_clr together with an illegal push -> err_cnt=0.
- Async reset in FULL: assert reset_n between edges -> out_valid=0 immediately; after release no stale entry appears.
